// File: rtl/haraka_256_v2_core.sv
// haraka_256_v2_core: iterative Haraka-256 v2, one AES round per block per cycle, 10-cycle latency
module haraka_256_v2_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [255:0] in,
   output logic [255:0] out,
   output logic         busy,
   output logic         done
);
   typedef logic [0:15][7:0] blk_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // round constants as little-endian 128-bit words: constant byte 0 sits in [7:0]
   localparam logic [127:0] RC [20] = '{
      128'h0684704c_e620c00a_b2c5fef0_75817b9d, 128'h8b66b4e1_88f3a06b_640f6ba4_2f08f717,
      128'h3402de2d_53f28498_cf029d60_9f029114, 128'h0ed6eae6_2e7b4f08_bbf3bcaf_fd5b4f79,
      128'hcbcfb0cb_4872448b_79eecd1c_be397044, 128'h7eeacdee_6e9032b7_8d5335ed_2b8a057b,
      128'h67c28f43_5e2e7cd0_e2412761_da4fef1b, 128'h2924d9b0_afcacc07_675ffde2_1fc70b3b,
      128'hab4d63f1_e6867fe9_ecdb8fca_b9d465ee, 128'h1c30bf84_d4b7cd64_5b2a404f_ad037e33,
      128'hb2cc0bb9_941723bf_69028b2e_8df69800, 128'hfa0478a6_de6f5572_4aaa9ec8_5c9d2d8a,
      128'hdfb49f2b_6b772a12_0efa4f2e_29129fd4, 128'h1ea10344_f449a236_32d611ae_bb6a12ee,
      128'haf044988_4b050084_5f9600c9_9ca8eca6, 128'h21025ed8_9d199c4f_78a2c7e3_27e593ec,
      128'hbf3aaaf8_a759c9b7_b9282ecd_82d40173, 128'h6260700d_6186b017_37f2efd9_10307d6b,
      128'h5aca45c2_21300443_81c29153_f6fc9ac6, 128'h9223973c_226b68bb_2caf92e8_36d1943a
   };

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // byte-reverse so that constant byte 0 lines up with state byte 0
   function automatic blk_t rc(input logic [4:0] i);
      blk_t r;
      r = {<<8{RC[i]}};
      return r;
   endfunction

   // AESENC: SubBytes + ShiftRows folded into one gather, then MixColumns and key XOR
   function automatic blk_t aes_enc(input blk_t s, input blk_t k);
      blk_t t;
      blk_t r;
      int   c;
      for (int j = 0; j < 16; j++) t[j] = SBOX[s[(j + 4 * (j % 4)) % 16]];
      for (int j = 0; j < 16; j++) begin
         c    = j - j % 4;
         r[j] = xt(t[j]) ^ xt(t[c + (j + 1) % 4]) ^ t[c + (j + 1) % 4]
              ^ t[c + (j + 2) % 4] ^ t[c + (j + 3) % 4] ^ k[j];
      end
      return r;
   endfunction

   logic [255:0] st_q, st_d, msg_q, msg_d, out_q, out_d, nxt;
   logic [127:0] a_e, b_e;
   logic [3:0]   cnt_q, cnt_d;
   logic         busy_q, busy_d, done_q, done_d;

   // one AES round per block per cycle; odd cycles close a Haraka round with MIX
   always_comb begin
      a_e    = aes_enc(st_q[255:128], rc({cnt_q, 1'b0}));
      b_e    = aes_enc(st_q[127:0], rc({cnt_q, 1'b1}));
      nxt    = cnt_q[0] ? {a_e[127:96], b_e[127:96], a_e[95:64], b_e[95:64],
                           a_e[63:32], b_e[63:32], a_e[31:0], b_e[31:0]} : {a_e, b_e};
      st_d   = st_q;
      msg_d  = msg_q;
      out_d  = out_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (busy_q) begin
         st_d  = nxt;
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == 4'd9) begin
            cnt_d  = 4'd0;
            busy_d = 1'b0;
            done_d = 1'b1;
            out_d  = nxt ^ msg_q;
         end
      end else if (start) begin
         st_d   = in;
         msg_d  = in;
         cnt_d  = 4'd0;
         busy_d = 1'b1;
      end
   end

   // state registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= '0;
         msg_q  <= '0;
         out_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         msg_q  <= msg_d;
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_haraka_256_v2_core.sv
// tb_haraka_256_v2_core: directed and random checks of the Haraka-256 v2 core against a byte-level model
module tb_haraka_256_v2_core;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [255:0] in = '0;
   logic [255:0] out;
   logic         busy, done;
   int           nchk = 0;
   int           npass = 0;
   logic [7:0]   sbox [256];

   localparam logic [255:0] MSG = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] DIG = 256'h8027ccb87949774b78d0545fb72bf70c695c2a0923cbd47bba1159efbf2b2c1c;

   logic [127:0] rcv [20] = '{
      128'h0684704c_e620c00a_b2c5fef0_75817b9d, 128'h8b66b4e1_88f3a06b_640f6ba4_2f08f717,
      128'h3402de2d_53f28498_cf029d60_9f029114, 128'h0ed6eae6_2e7b4f08_bbf3bcaf_fd5b4f79,
      128'hcbcfb0cb_4872448b_79eecd1c_be397044, 128'h7eeacdee_6e9032b7_8d5335ed_2b8a057b,
      128'h67c28f43_5e2e7cd0_e2412761_da4fef1b, 128'h2924d9b0_afcacc07_675ffde2_1fc70b3b,
      128'hab4d63f1_e6867fe9_ecdb8fca_b9d465ee, 128'h1c30bf84_d4b7cd64_5b2a404f_ad037e33,
      128'hb2cc0bb9_941723bf_69028b2e_8df69800, 128'hfa0478a6_de6f5572_4aaa9ec8_5c9d2d8a,
      128'hdfb49f2b_6b772a12_0efa4f2e_29129fd4, 128'h1ea10344_f449a236_32d611ae_bb6a12ee,
      128'haf044988_4b050084_5f9600c9_9ca8eca6, 128'h21025ed8_9d199c4f_78a2c7e3_27e593ec,
      128'hbf3aaaf8_a759c9b7_b9282ecd_82d40173, 128'h6260700d_6186b017_37f2efd9_10307d6b,
      128'h5aca45c2_21300443_81c29153_f6fc9ac6, 128'h9223973c_226b68bb_2caf92e8_36d1943a
   };

   haraka_256_v2_core dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .in   (in),
      .out  (out),
      .busy (busy),
      .done (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box derived from first principles: GF(2^8) inverse followed by the AES affine map
   task automatic build_sbox();
      logic [7:0] inv, r, acc;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         r   = inv;
         acc = inv;
         for (int n = 0; n < 4; n++) begin
            r   = {r[6:0], r[7]};
            acc = acc ^ r;
         end
         sbox[x] = acc ^ 8'h63;
      end
   endtask

   function automatic logic [255:0] model(input logic [255:0] m);
      logic [7:0]   s [32];
      logic [7:0]   u [32];
      logic [7:0]   t [16];
      logic [255:0] r;
      for (int i = 0; i < 32; i++) s[i] = m[255 - 8 * i -: 8];
      for (int rd = 0; rd < 5; rd++) begin
         for (int a = 0; a < 2; a++)
            for (int bl = 0; bl < 2; bl++) begin
               for (int c = 0; c < 4; c++)
                  for (int w = 0; w < 4; w++) t[4 * c + w] = sbox[s[16 * bl + 4 * ((c + w) % 4) + w]];
               for (int c = 0; c < 4; c++)
                  for (int w = 0; w < 4; w++)
                     s[16 * bl + 4 * c + w] = gmul(8'h02, t[4 * c + w]) ^ gmul(8'h03, t[4 * c + (w + 1) % 4])
                        ^ t[4 * c + (w + 2) % 4] ^ t[4 * c + (w + 3) % 4]
                        ^ rcv[4 * rd + 2 * a + bl][8 * (4 * c + w) +: 8];
            end
         u = s;
         for (int j = 0; j < 8; j++)
            for (int y = 0; y < 4; y++) s[4 * j + y] = u[4 * (4 * (j % 2) + j / 2) + y];
      end
      for (int i = 0; i < 32; i++) r[255 - 8 * i -: 8] = s[i] ^ m[255 - 8 * i -: 8];
      return r;
   endfunction

   task automatic launch(input logic [255:0] m);
      in    = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 30);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [255:0] m;
      int           n, nd, first, cyc;
      build_sbox();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_out", out, '0);
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_done", 256'(done), 256'(0));

      launch(MSG);
      in = '1;
      check("busy_set", 256'(busy), 256'(1));
      wait_done(n);
      check("gold_lat", 256'(n), 256'(10));
      check("gold_blk0", 256'(out[255:128]), 256'(DIG[255:128]));
      check("gold_blk1", 256'(out[127:0]), 256'(DIG[127:0]));
      check("busy_drop", 256'(busy), 256'(0));
      @(posedge clk);
      #1;
      check("done_pulse", 256'(done), 256'(0));
      check("out_hold", out, DIG);

      launch(MSG);
      wait_done(n);
      check("b2b_lat1", 256'(n), 256'(10));
      check("b2b_out1", out, DIG);
      in    = '0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      in    = {8{$urandom}};
      check("b2b_busy", 256'(busy), 256'(1));
      check("b2b_nointerm", out, DIG);
      wait_done(n);
      check("b2b_lat2", 256'(n), 256'(10));
      check("b2b_out2", out, model('0));

      launch(MSG);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      in    = '1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 4;
      nd    = 0;
      first = 0;
      while (cyc < 24) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin
            nd++;
            if (first == 0) first = cyc;
         end
      end
      check("ign_dones", 256'(nd), 256'(1));
      check("ign_lat", 256'(first), 256'(10));
      check("ign_out", out, DIG);

      launch(MSG);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check("abort_out", out, '0);
      check("abort_busy", 256'(busy), 256'(0));
      check("abort_done", 256'(done), 256'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      nd    = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (done) nd++;
      end
      check("abort_nodone", 256'(nd), 256'(0));
      check("abort_idle", out, '0);
      launch(MSG);
      wait_done(n);
      check("rerun_lat", 256'(n), 256'(10));
      check("rerun_out", out, DIG);

      for (int k = 0; k < 1000; k++) begin
         m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         launch(m);
         in = ~m;
         wait_done(n);
         check("rnd_lat", 256'(n), 256'(10));
         check("rnd_out", out, model(m));
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
